// File: rtl/regfile_pkg.sv
// Shared constants and types for the 8 x 16-bit register file.
// r0 is architectural zero; r3 carries the function return value.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int RET_REG  = 3;

  typedef logic [DATA_W-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One registered read port with write-first bypass; 1-cycle latency, no backpressure.
// Address 0 reads zero because regs_i[0] is tied low and writes to r0 never bypass.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                raddr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  input  logic                             we_i,
  input  logic [ADDR_W-1:0]                waddr_i,
  input  logic [DATA_W-1:0]                wdata_i,
  output logic [DATA_W-1:0]                rdata_o
);

  word_t rdata_d;
  word_t rdata_q;
  logic  bypass;

  assign bypass = we_i && (waddr_i != '0) && (waddr_i == raddr_i);

  always_comb begin
    rdata_d = regs_i[raddr_i];
    if (bypass) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : regfile_rdport

// File: rtl/regfile.sv
// Two-read / one-write register file, r1..r7 in flops, r0 hardwired to zero.
// Reads land one cycle after the address (write-first bypass); no backpressure.
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr_1,
  output logic [DATA_W-1:0] rdata_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic [DATA_W-1:0] rdata_2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ret_val,
  input  logic              rst_n
);

  word_t regs_q [1:NUM_REGS-1];
  word_t regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_view;

  // Loop starts at 1, so a write aimed at r0 matches nothing and is dropped.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == ADDR_W'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    regs_view = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  regfile_rdport u_rdport_1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_i (raddr_1),
    .regs_i  (regs_view),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata_1)
  );

  regfile_rdport u_rdport_2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_i (raddr_2),
    .regs_i  (regs_view),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata_2)
  );

  // Stored value only: a write to r3 shows up here after the edge, never bypassed.
  assign ret_val = regs_q[RET_REG];

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, r0, bypass, ret_val, dual-port.
module tb_regfile;

  logic        clk;
  logic [2:0]  raddr_1;
  logic [15:0] rdata_1;
  logic [2:0]  raddr_2;
  logic [15:0] rdata_2;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] ret_val;
  logic        rst_n;

  int checks   = 0;
  int failures = 0;

  regfile dut (
    .clk     (clk),
    .raddr_1 (raddr_1),
    .rdata_1 (rdata_1),
    .raddr_2 (raddr_2),
    .rdata_2 (rdata_2),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ret_val (ret_val),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    we      = 1'b0;
    waddr   = 3'd0;
    wdata   = 16'h0000;
    raddr_1 = 3'd0;
    raddr_2 = 3'd0;
    step();
    step();
    chk("reset_rdata_1", rdata_1, 16'h0000);
    chk("reset_rdata_2", rdata_2, 16'h0000);
    chk("reset_ret_val", ret_val, 16'h0000);

    // Release with a write presented on the first active edge.
    rst_n = 1'b1;
    we    = 1'b1;
    waddr = 3'd1;
    wdata = 16'h1111;
    step();
    for (int i = 2; i < 8; i++) begin
      waddr = 3'(i);
      wdata = {4{4'(i)}};
      step();
    end
    we      = 1'b0;
    raddr_1 = 3'd1;
    raddr_2 = 3'd7;
    step();
    chk("release_write_r1", rdata_1, 16'h1111);
    chk("fill_r7", rdata_2, 16'h7777);
    chk("fill_ret_val", ret_val, 16'h3333);

    // Asynchronous reset with an in-flight write to r4.
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdata_1", rdata_1, 16'h0000);
    chk("async_rst_rdata_2", rdata_2, 16'h0000);
    chk("async_rst_ret_val", ret_val, 16'h0000);
    we      = 1'b1;
    waddr   = 3'd4;
    wdata   = 16'hDEAD;
    raddr_1 = 3'd4;
    raddr_2 = 3'd4;
    step();
    chk("rst_blocks_capture", rdata_1, 16'h0000);
    we    = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      raddr_1 = 3'(i);
      raddr_2 = 3'(8 - i);
      step();
      chk($sformatf("post_rst_p1_r%0d", i), rdata_1, 16'h0000);
      chk($sformatf("post_rst_p2_r%0d", 8 - i), rdata_2, 16'h0000);
    end

    // Write r5 then read it one cycle later.
    we    = 1'b1;
    waddr = 3'd5;
    wdata = 16'h1234;
    raddr_1 = 3'd0;
    step();
    we      = 1'b0;
    raddr_1 = 3'd5;
    step();
    chk("write_read_r5", rdata_1, 16'h1234);

    // X on write inputs with we=0 must not disturb storage.
    waddr = 3'bxxx;
    wdata = 16'hxxxx;
    step();
    waddr = 3'd0;
    wdata = 16'h0000;
    step();
    chk("x_inputs_r5", rdata_1, 16'h1234);

    // Write to r0 is dropped; read of r0 is zero even on the same edge.
    we      = 1'b1;
    waddr   = 3'd0;
    wdata   = 16'hFFFF;
    raddr_1 = 3'd0;
    raddr_2 = 3'd0;
    step();
    chk("r0_same_edge_p1", rdata_1, 16'h0000);
    chk("r0_same_edge_p2", rdata_2, 16'h0000);
    we = 1'b0;
    step();
    chk("r0_after_p1", rdata_1, 16'h0000);
    chk("r0_after_p2", rdata_2, 16'h0000);

    // Write-first bypass on both ports.
    we      = 1'b1;
    waddr   = 3'd2;
    wdata   = 16'hBEEF;
    raddr_1 = 3'd2;
    raddr_2 = 3'd2;
    step();
    chk("bypass_p1", rdata_1, 16'hBEEF);
    chk("bypass_p2", rdata_2, 16'hBEEF);
    we = 1'b0;
    step();
    chk("bypass_stored_p1", rdata_1, 16'hBEEF);

    // ret_val follows stored r3 only.
    we    = 1'b1;
    waddr = 3'd3;
    wdata = 16'h00A5;
    #1;
    chk("ret_val_no_bypass", ret_val, 16'h0000);
    step();
    chk("ret_val_r3", ret_val, 16'h00A5);
    waddr = 3'd4;
    wdata = 16'h0044;
    step();
    chk("ret_val_r4_write", ret_val, 16'h00A5);

    // Independent ports.
    waddr = 3'd6;
    wdata = 16'h0006;
    step();
    waddr = 3'd7;
    wdata = 16'h0007;
    step();
    we      = 1'b0;
    raddr_1 = 3'd6;
    raddr_2 = 3'd7;
    step();
    chk("dual_p1_r6", rdata_1, 16'h0006);
    chk("dual_p2_r7", rdata_2, 16'h0007);
    raddr_1 = 3'd4;
    raddr_2 = 3'd4;
    step();
    chk("same_addr_p1", rdata_1, 16'h0044);
    chk("same_addr_p2", rdata_2, 16'h0044);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile
